// File: rtl/floating_point_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : floating_point_unit_pkg
// Purpose  : Shared FPU types and constants (rounding modes, GRS bits, float32)
// Revision : 1.0 - initial release
// ============================================================================
package floating_point_unit_pkg;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } rnd_mode_t;

    typedef struct packed {
        logic guard;
        logic round;
        logic sticky;
    } round_bits_t;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] significand;
    } float32_t;

    localparam logic [31:0] MAX_FLOAT32 = 32'h7F7F_FFFF;
    localparam logic [7:0]  INF_EXP     = 8'hFF;
    localparam logic [31:0] INT32_MAX   = 32'h7FFF_FFFF;
    localparam logic [31:0] INT32_MIN   = 32'h8000_0000;
    localparam logic [31:0] UINT32_MAX  = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/floating_point_rounder_round_up_decision.sv
`default_nettype none
// ============================================================================
// Module   : round_up_decision
// Purpose  : Combinational round-up decision from mode, sign, lsb and GRS bits
// Revision : 1.0 - initial release
// ============================================================================
module round_up_decision
    import floating_point_unit_pkg::*;
(
    input  logic [2:0] i_mode,
    input  logic       i_sign,
    input  logic       i_lsb,
    input  logic       i_guard,
    input  logic       i_round,
    input  logic       i_sticky,
    output logic       o_round_up,
    output logic       o_illegal
);

    logic w_any;

    assign w_any = i_guard | i_round | i_sticky;

    always_comb begin
        o_round_up = 1'b0;
        o_illegal  = 1'b0;
        case (i_mode)
            RNE:     o_round_up = i_guard & (i_round | i_sticky | i_lsb);
            RTZ:     o_round_up = 1'b0;
            RDN:     o_round_up = i_sign & w_any;
            RUP:     o_round_up = ~i_sign & w_any;
            RMM:     o_round_up = i_guard;
            default: o_illegal  = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/floating_point_rounder.sv
`default_nettype none
// ============================================================================
// Module   : floating_point_rounder
// Purpose  : Two-stage rounder for float32 / int32 FPU results with flags.
//            Optional sticky fflags accumulator: define FP_ROUND_FLAGS_ACC_EN.
// Revision : 1.0 - initial release
// ============================================================================
module floating_point_rounder
    import floating_point_unit_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
`ifdef FP_ROUND_FLAGS_ACC_EN
    input  logic        clear_flags_i,
    output logic [4:0]  fflags_o,
`endif
    input  logic        clk_en_i,
    input  logic        data_valid_i,
    input  logic [31:0] operand_i,
    input  round_bits_t round_bits_i,
    input  logic [2:0]  rounding_mode_i,
    input  logic        is_integer_i,
    input  logic        signed_i,
    input  logic        sign_i,
    input  logic        overflow_i,
    input  logic        underflow_i,
    input  logic        inexact_i,
    output logic [31:0] result_o,
    output logic        data_valid_o,
    output logic        inexact_o,
    output logic        overflow_o,
    output logic        underflow_o,
    output logic        illegal_mode_o
);

    logic        w_round_up;
    logic        w_illegal;

    logic        r_s1_valid;
    logic [31:0] r_s1_operand;
    logic [2:0]  r_s1_mode;
    logic        r_s1_round_up;
    logic        r_s1_illegal;
    logic        r_s1_any;
    logic        r_s1_is_int;
    logic        r_s1_signed;
    logic        r_s1_sign;
    logic        r_s1_ovf;
    logic        r_s1_unf;
    logic        r_s1_inx;

    logic [30:0] w_float_sum;
    logic [32:0] w_int_delta;
    logic [32:0] w_sint_sum;
    logic [32:0] w_uint_sum;
    logic [31:0] w_result;
    logic        w_nx;
    logic        w_of;
    logic        w_uf;
    logic        w_sat;

    logic        r_valid;
    logic [31:0] r_result;
    logic        r_nx;
    logic        r_of;
    logic        r_uf;
    logic        r_il;

    round_up_decision u_round_up_decision (
        .i_mode     (rounding_mode_i),
        .i_sign     (sign_i),
        .i_lsb      (operand_i[0]),
        .i_guard    (round_bits_i.guard),
        .i_round    (round_bits_i.round),
        .i_sticky   (round_bits_i.sticky),
        .o_round_up (w_round_up),
        .o_illegal  (w_illegal)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s1_valid    <= 1'b0;
            r_s1_operand  <= '0;
            r_s1_mode     <= '0;
            r_s1_round_up <= 1'b0;
            r_s1_illegal  <= 1'b0;
            r_s1_any      <= 1'b0;
            r_s1_is_int   <= 1'b0;
            r_s1_signed   <= 1'b0;
            r_s1_sign     <= 1'b0;
            r_s1_ovf      <= 1'b0;
            r_s1_unf      <= 1'b0;
            r_s1_inx      <= 1'b0;
        end else if (clk_en_i) begin
            r_s1_valid    <= data_valid_i;
            r_s1_operand  <= operand_i;
            r_s1_mode     <= rounding_mode_i;
            r_s1_round_up <= w_round_up;
            r_s1_illegal  <= w_illegal;
            r_s1_any      <= |round_bits_i;
            r_s1_is_int   <= is_integer_i;
            r_s1_signed   <= signed_i;
            r_s1_sign     <= sign_i;
            r_s1_ovf      <= overflow_i;
            r_s1_unf      <= underflow_i;
            r_s1_inx      <= inexact_i;
        end
    end

    // Integer rounding moves the magnitude away from zero, so a negative value steps by -1.
    assign w_float_sum = r_s1_operand[30:0] + {30'd0, r_s1_round_up};
    assign w_int_delta = r_s1_round_up ? (r_s1_sign ? {33{1'b1}} : 33'd1) : 33'd0;
    assign w_sint_sum  = {r_s1_operand[31], r_s1_operand} + w_int_delta;
    assign w_uint_sum  = {1'b0, r_s1_operand} + {32'd0, r_s1_round_up};

    always_comb begin
        w_result = r_s1_operand;
        w_nx     = r_s1_inx | r_s1_any;
        w_of     = r_s1_ovf;
        w_uf     = r_s1_unf;
        w_sat    = 1'b0;
        if (r_s1_is_int) begin
            if (r_s1_signed) begin
                if (w_sint_sum[32] != w_sint_sum[31]) begin
                    w_sat    = 1'b1;
                    w_of     = 1'b1;
                    w_result = w_sint_sum[32] ? INT32_MIN : INT32_MAX;
                end else begin
                    w_result = w_sint_sum[31:0];
                end
            end else if (r_s1_sign && ((r_s1_operand != 32'd0) || r_s1_round_up)) begin
                w_sat    = 1'b1;
                w_uf     = 1'b1;
                w_result = 32'd0;
            end else if (w_uint_sum[32]) begin
                w_sat    = 1'b1;
                w_of     = 1'b1;
                w_result = UINT32_MAX;
            end else begin
                w_result = w_uint_sum[31:0];
            end
            if (w_sat) begin
                w_nx = 1'b0;
            end
        end else if (r_s1_operand[30:23] == INF_EXP) begin
            w_nx = r_s1_inx;
        end else begin
            w_uf = r_s1_unf & r_s1_any;
            if (w_float_sum[30:23] == INF_EXP) begin
                w_of = 1'b1;
                w_nx = 1'b1;
                case (r_s1_mode)
                    RTZ:     w_result = {r_s1_sign, MAX_FLOAT32[30:0]};
                    RDN:     w_result = r_s1_sign ? {1'b1, INF_EXP, 23'd0} : MAX_FLOAT32;
                    RUP:     w_result = r_s1_sign ? {1'b1, MAX_FLOAT32[30:0]} : {1'b0, INF_EXP, 23'd0};
                    default: w_result = {r_s1_sign, INF_EXP, 23'd0};
                endcase
            end else begin
                w_result = {r_s1_operand[31], w_float_sum};
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_nx     <= 1'b0;
            r_of     <= 1'b0;
            r_uf     <= 1'b0;
            r_il     <= 1'b0;
        end else if (clk_en_i) begin
            r_valid  <= r_s1_valid;
            r_result <= w_result;
            r_nx     <= w_nx & r_s1_valid;
            r_of     <= w_of & r_s1_valid;
            r_uf     <= w_uf & r_s1_valid;
            r_il     <= r_s1_illegal & r_s1_valid;
        end
    end

`ifdef FP_ROUND_FLAGS_ACC_EN
    logic [4:0] r_fflags;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fflags <= '0;
        end else if (clear_flags_i) begin
            r_fflags <= '0;
        end else if (clk_en_i && r_s1_valid) begin
            r_fflags <= r_fflags | {r_s1_illegal | w_sat, 1'b0, w_of, w_uf, w_nx};
        end
    end

    assign fflags_o = r_fflags;
`endif

    assign result_o       = r_result;
    assign data_valid_o   = r_valid;
    assign inexact_o      = r_nx;
    assign overflow_o     = r_of;
    assign underflow_o    = r_uf;
    assign illegal_mode_o = r_il;

endmodule
`default_nettype wire

// File: tb/tb_floating_point_rounder.sv
`default_nettype none
// ============================================================================
// Module   : tb_floating_point_rounder
// Purpose  : Directed vector table plus pipeline-hold and reset sequences
// Revision : 1.0 - initial release
// ============================================================================
module tb_floating_point_rounder;
    import floating_point_unit_pkg::*;

    typedef struct {
        logic [95:0] name;
        logic [31:0] op;
        logic [2:0]  grs;
        logic [2:0]  mode;
        logic        is_int;
        logic        sgn;
        logic        sign;
        logic        ovf;
        logic        unf;
        logic        inx;
        logic [31:0] res;
        logic        nx;
        logic        of;
        logic        uf;
        logic        il;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        clk_en;
    logic        valid_in;
    logic [31:0] operand;
    round_bits_t grs;
    logic [2:0]  mode;
    logic        is_int;
    logic        sgn;
    logic        sign;
    logic        ovf_in;
    logic        unf_in;
    logic        inx_in;
    logic [31:0] result;
    logic        valid_out;
    logic        nx_out;
    logic        of_out;
    logic        uf_out;
    logic        il_out;
`ifdef FP_ROUND_FLAGS_ACC_EN
    logic        clear_flags;
    logic [4:0]  fflags;
`endif

    int   checks;
    int   failures;
    vec_t vecs[$];

    floating_point_rounder dut (
        .clk_i           (clk),
        .rst_i           (rst),
`ifdef FP_ROUND_FLAGS_ACC_EN
        .clear_flags_i   (clear_flags),
        .fflags_o        (fflags),
`endif
        .clk_en_i        (clk_en),
        .data_valid_i    (valid_in),
        .operand_i       (operand),
        .round_bits_i    (grs),
        .rounding_mode_i (mode),
        .is_integer_i    (is_int),
        .signed_i        (sgn),
        .sign_i          (sign),
        .overflow_i      (ovf_in),
        .underflow_i     (unf_in),
        .inexact_i       (inx_in),
        .result_o        (result),
        .data_valid_o    (valid_out),
        .inexact_o       (nx_out),
        .overflow_o      (of_out),
        .underflow_o     (uf_out),
        .illegal_mode_o  (il_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic [95:0] nm, input logic [31:0] op, input logic [2:0] g,
                       input logic [2:0] md, input logic ii, input logic sg, input logic sn,
                       input logic ov, input logic un, input logic ix, input logic [31:0] res,
                       input logic nx, input logic of, input logic uf, input logic il);
        vec_t v;
        v.name = nm;  v.op = op;   v.grs = g;    v.mode = md;  v.is_int = ii;
        v.sgn = sg;   v.sign = sn; v.ovf = ov;   v.unf = un;   v.inx = ix;
        v.res = res;  v.nx = nx;   v.of = of;    v.uf = uf;    v.il = il;
        vecs.push_back(v);
    endtask

    task automatic check(input logic [95:0] nm, input logic [36:0] got, input logic [36:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got={res,nx,of,uf,il,vld}=%h required=%h", nm, got, exp);
        end
    endtask

    function automatic logic [36:0] outs();
        return {result, nx_out, of_out, uf_out, il_out, valid_out};
    endfunction

    task automatic drive(input vec_t v, input logic vld);
        operand  = v.op;
        grs      = v.grs;
        mode     = v.mode;
        is_int   = v.is_int;
        sgn      = v.sgn;
        sign     = v.sign;
        ovf_in   = v.ovf;
        unf_in   = v.unf;
        inx_in   = v.inx;
        valid_in = vld;
    endtask

    task automatic drive_rup(input logic [31:0] op);
        operand  = op;
        grs      = 3'b001;
        mode     = 3'b011;
        is_int   = 1'b0;
        sgn      = 1'b0;
        sign     = 1'b0;
        ovf_in   = 1'b0;
        unf_in   = 1'b0;
        inx_in   = 1'b0;
        valid_in = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        clk_en   = 1'b1;
        valid_in = 1'b0;
        operand  = '0;
        grs      = '0;
        mode     = '0;
        is_int   = 1'b0;
        sgn      = 1'b0;
        sign     = 1'b0;
        ovf_in   = 1'b0;
        unf_in   = 1'b0;
        inx_in   = 1'b0;
`ifdef FP_ROUND_FLAGS_ACC_EN
        clear_flags = 1'b0;
`endif

        //   name            op            grs     md  int sg sn ov un ix  result        nx of uf il
        add("rne_tie_odd",  32'h3F800001, 3'b100, 0, 0, 0, 0, 0, 0, 0, 32'h3F800002, 1, 0, 0, 0);
        add("rne_tie_even", 32'h3F800000, 3'b100, 0, 0, 0, 0, 0, 0, 0, 32'h3F800000, 1, 0, 0, 0);
        add("rne_exact",    32'h3F800000, 3'b000, 0, 0, 0, 0, 0, 0, 0, 32'h3F800000, 0, 0, 0, 0);
        add("rup_carry",    32'h3FFFFFFF, 3'b001, 3, 0, 0, 0, 0, 0, 0, 32'h40000000, 1, 0, 0, 0);
        add("ovf_rne",      32'h7F7FFFFF, 3'b110, 0, 0, 0, 0, 0, 0, 0, 32'h7F800000, 1, 1, 0, 0);
        add("ovf_rtz",      32'h7F7FFFFF, 3'b110, 1, 0, 0, 0, 0, 0, 0, 32'h7F7FFFFF, 1, 0, 0, 0);
        add("neg_rup",      32'hFF7FFFFF, 3'b110, 3, 0, 0, 1, 0, 0, 0, 32'hFF7FFFFF, 1, 0, 0, 0);
        add("ovf_rdn_neg",  32'hFF7FFFFF, 3'b001, 2, 0, 0, 1, 0, 0, 0, 32'hFF800000, 1, 1, 0, 0);
        add("ovf_rmm",      32'h7F7FFFFF, 3'b100, 4, 0, 0, 0, 0, 0, 0, 32'h7F800000, 1, 1, 0, 0);
        add("int_sat_max",  32'h7FFFFFFF, 3'b100, 4, 1, 1, 0, 0, 0, 0, 32'h7FFFFFFF, 0, 1, 0, 0);
        add("int_neg_rdn",  32'hFFFFFFFB, 3'b001, 2, 1, 1, 1, 0, 0, 0, 32'hFFFFFFFA, 1, 0, 0, 0);
        add("int_sat_min",  32'h80000000, 3'b100, 2, 1, 1, 1, 0, 0, 0, 32'h80000000, 0, 1, 0, 0);
        add("int_rup",      32'h00000007, 3'b001, 3, 1, 1, 0, 0, 0, 0, 32'h00000008, 1, 0, 0, 0);
        add("uint_sat",     32'hFFFFFFFF, 3'b010, 3, 1, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 0, 1, 0, 0);
        add("uint_neg",     32'h00000000, 3'b001, 2, 1, 0, 1, 0, 0, 0, 32'h00000000, 0, 0, 1, 0);
        add("uint_neg_rtz", 32'h00000000, 3'b001, 1, 1, 0, 1, 0, 0, 0, 32'h00000000, 1, 0, 0, 0);
        add("uint_rne",     32'h00000005, 3'b110, 0, 1, 0, 0, 0, 0, 0, 32'h00000006, 1, 0, 0, 0);
        add("illegal_101",  32'h12345678, 3'b111, 5, 0, 0, 0, 0, 0, 0, 32'h12345678, 1, 0, 0, 1);
        add("nan_rup",      32'h7FC00000, 3'b111, 3, 0, 0, 0, 0, 0, 0, 32'h7FC00000, 0, 0, 0, 0);
        add("unf_exact",    32'h00000001, 3'b000, 0, 0, 0, 0, 0, 1, 0, 32'h00000001, 0, 0, 0, 0);
        add("unf_inexact",  32'h00000001, 3'b001, 0, 0, 0, 0, 0, 1, 0, 32'h00000001, 1, 0, 1, 0);
        add("ovf_upstream", 32'h3F800000, 3'b000, 0, 0, 0, 0, 1, 0, 0, 32'h3F800000, 0, 1, 0, 0);
        add("rmm_up",       32'h3F800000, 3'b100, 4, 0, 0, 0, 0, 0, 0, 32'h3F800001, 1, 0, 0, 0);
        add("rdn_neg",      32'hBF800000, 3'b001, 2, 0, 0, 1, 0, 0, 0, 32'hBF800001, 1, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1 check("reset_state", outs(), 37'd0);
        @(negedge clk) rst = 1'b0;

        // Each vector: drive on a falling edge, result visible two rising edges later.
        foreach (vecs[i]) begin
            @(negedge clk) drive(vecs[i], 1'b1);
            @(negedge clk) valid_in = 1'b0;
            @(negedge clk) check(vecs[i].name, outs(),
                                 {vecs[i].res, vecs[i].nx, vecs[i].of, vecs[i].uf, vecs[i].il, 1'b1});
        end

        // Back-to-back stream with clk_en_i dropping; B is held upstream while stalled.
        @(negedge clk) begin drive_rup(32'h3F800000); clk_en = 1'b1; end
        @(negedge clk) begin drive_rup(32'h40000000); clk_en = 1'b0; end
        @(negedge clk) begin check("pipe_empty", {31'd0, valid_out}, 32'd0); clk_en = 1'b1; end
        @(negedge clk) begin check("pipe_a", outs(), {32'h3F800001, 4'b1000, 1'b1}); drive_rup(32'h40400000); end
        @(negedge clk) begin check("pipe_b", outs(), {32'h40000001, 4'b1000, 1'b1}); clk_en = 1'b0; valid_in = 1'b0; end
        @(negedge clk) begin check("pipe_hold", outs(), {32'h40000001, 4'b1000, 1'b1}); clk_en = 1'b1; end
        @(negedge clk) check("pipe_c", outs(), {32'h40400001, 4'b1000, 1'b1});
        @(negedge clk) check("pipe_drain", {31'd0, valid_out}, 32'd0);

        // Reset with two results in flight.
        @(negedge clk) drive_rup(32'h3F800000);
        @(negedge clk) drive_rup(32'h40000000);
        @(negedge clk) begin valid_in = 1'b0; rst = 1'b1; end
        #1 check("rst_flush", outs(), 37'd0);
        @(negedge clk) rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk) check("rst_no_emit", {31'd0, valid_out}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
